regfile_rename: RTL and testbench
=================================

REGFILE_RENAME -- requirements
Module: regfile_rename

Interface
REQ-001 SHALL have parameter XLEN, default 32, architectural data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count (power of two, >=2).
REQ-003 SHALL have parameter ROB_TAG_W, default 4, ROB tag width.
REQ-004 SHALL have parameter NRD, default 2, number of read ports; IDX_W = clog2(NREG) is derived, not overridable.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-008 SHALL have port rd_idx  input  NRD*IDX_W  read register indices, port p at bits [p*IDX_W +: IDX_W].
REQ-009 SHALL have port rd_value  output  NRD*XLEN  read values, same packing.
REQ-010 SHALL have port rd_tag  output  NRD*ROB_TAG_W  pending ROB tag per read port.
REQ-011 SHALL have port rd_busy  output  NRD  register awaits a ROB result.
REQ-012 SHALL have ports ren_valid  input  1; ren_reg  input  IDX_W; ren_tag  input  ROB_TAG_W  decoder rename of a destination.
REQ-013 SHALL have ports cmt_valid  input  1; cmt_reg  input  IDX_W; cmt_tag  input  ROB_TAG_W; cmt_value  input  XLEN  ROB commit.
REQ-014 SHALL have port flush  input  1  misprediction flush.
REQ-015 SHALL have port busy_cnt  output  IDX_W+1  number of registers currently busy (registered).

Function
REQ-016 Reads SHALL be combinational from stored value/tag/busy; rd_idx of 0 SHALL return value 0, tag 0, busy 0.
REQ-017 Register 0 SHALL never be written by rename or commit.
REQ-018 On an edge with rdy=1, ren_valid=1, flush=0, ren_reg!=0: tag[ren_reg]<=ren_tag, busy[ren_reg]<=1.
REQ-019 On an edge with rdy=1, cmt_valid=1, cmt_reg!=0: value[cmt_reg]<=cmt_value; busy[cmt_reg]<=0 only if tag[cmt_reg]==cmt_tag and no same-register rename is applied that edge.
REQ-020 Commit with a tag mismatch SHALL update value only; busy and tag stay unchanged.
REQ-021 Rename and commit to the same register on one edge: value<=cmt_value, tag<=ren_tag, busy stays 1.
REQ-022 flush=1 with rdy=1 SHALL clear every busy bit on that edge, ignore ren_valid, and still apply the commit value write; tags stay unchanged.
REQ-023 rdy=0 SHALL block all writes, rename, commit and flush, regardless of other inputs.
REQ-024 busy_cnt SHALL equal the population count of busy bits after each edge, range 0..NREG-1, no wrap; rename of an already-busy register SHALL not increment it.

Reset
REQ-025 rst=1 SHALL immediately, independent of clk, clear all values, tags, busy bits and busy_cnt to 0.
REQ-026 Reset asserted mid-operation SHALL discard same-cycle rename/commit/flush; first update occurs on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: a read port SHALL return rd_value=cmt_value and rd_busy=0 when cmt_valid=1, rdy=1, rd_idx==cmt_reg!=0, busy[rd_idx]=1 and tag[rd_idx]==cmt_tag (same-cycle forwarding).
REQ-028 Macro REGFILE_BYPASS_EN undefined: read ports SHALL reflect stored state only; committed data visible the cycle after commit.

Verification
REQ-029 Reset, then read x5 -> value 0, tag 0, busy 0, busy_cnt 0.
REQ-030 Rename x5 tag 3, then commit x5 tag 3 value 0xDEADBEEF -> next cycle busy 0, value 0xDEADBEEF, busy_cnt returns 1->0.
REQ-031 Rename x7 tag 2, rename x7 tag 6, commit x7 tag 2 value 0x11 -> value 0x11, busy 1, tag 6.
REQ-032 Same edge rename x9 tag 4 and commit x9 tag 1 value 0x22 -> value 0x22, tag 4, busy 1; rename/commit x0 -> x0 reads 0, not busy.
REQ-033 Rename x1,x2,x3 then flush with commit x4 value 0x33 -> all busy 0, busy_cnt 0, x4 value 0x33; rdy=0 during same stimulus -> no change.
REQ-034 With REGFILE_BYPASS_EN: rename x10 tag 5, next cycle commit x10 tag 5 value 0x44 with rd_idx=10 -> same-cycle rd_value 0x44, rd_busy 0; without macro -> rd_busy 1 that cycle, value 0x44 the next.

Source files
------------

// File: rtl/regfile_rename.sv
// ============================================================================
// Module   : regfile_rename
// Brief    : Architectural register file with per-register ROB rename tags,
//            busy tracking, commit write-back and flush. Optional same-cycle
//            commit forwarding on read ports when REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rename #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int ROB_TAG_W = 4,
  parameter int NRD       = 2,
  localparam int IDX_W    = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NRD*IDX_W-1:0]     rd_idx,
  output logic [NRD*XLEN-1:0]      rd_value,
  output logic [NRD*ROB_TAG_W-1:0] rd_tag,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     ren_valid,
  input  logic [IDX_W-1:0]         ren_reg,
  input  logic [ROB_TAG_W-1:0]     ren_tag,
  input  logic                     cmt_valid,
  input  logic [IDX_W-1:0]         cmt_reg,
  input  logic [ROB_TAG_W-1:0]     cmt_tag,
  input  logic [XLEN-1:0]          cmt_value,
  input  logic                     flush,
  output logic [IDX_W:0]           busy_cnt
);

  logic [NREG-1:0][XLEN-1:0]      value_q, value_d;
  logic [NREG-1:0][ROB_TAG_W-1:0] tag_q, tag_d;
  logic [NREG-1:0]                busy_q, busy_d;
  logic [IDX_W:0]                 cnt_q, cnt_d;
  logic                           ren_hit;
  logic                           cmt_hit;

  assign ren_hit = ren_valid && !flush && (ren_reg != '0);
  assign cmt_hit = cmt_valid && (cmt_reg != '0);

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    cnt_d   = '0;

    // A same-edge rename of the committing register keeps it busy under the new tag.
    if (cmt_hit) begin
      value_d[cmt_reg] = cmt_value;
      if ((tag_q[cmt_reg] == cmt_tag) && !(ren_hit && (ren_reg == cmt_reg))) begin
        busy_d[cmt_reg] = 1'b0;
      end
    end

    if (flush) begin
      busy_d = '0;
    end else if (ren_hit) begin
      tag_d[ren_reg]  = ren_tag;
      busy_d[ren_reg] = 1'b1;
    end

    for (int i = 1; i < NREG; i++) begin
      cnt_d = cnt_d + {{IDX_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      tag_q   <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else if (rdy) begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IDX_W-1:0] idx;
    logic             nz;

    assign idx = rd_idx[p*IDX_W +: IDX_W];
    assign nz  = (idx != '0);
    assign rd_tag[p*ROB_TAG_W +: ROB_TAG_W] = nz ? tag_q[idx] : '0;

`ifdef REGFILE_BYPASS_EN
    logic fwd;

    assign fwd = nz && rdy && cmt_valid && (cmt_reg == idx) &&
                 busy_q[idx] && (tag_q[idx] == cmt_tag);
    assign rd_value[p*XLEN +: XLEN] = fwd ? cmt_value : (nz ? value_q[idx] : '0);
    assign rd_busy[p]               = nz && busy_q[idx] && !fwd;
`else
    assign rd_value[p*XLEN +: XLEN] = nz ? value_q[idx] : '0;
    assign rd_busy[p]               = nz && busy_q[idx];
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_rename.sv
// Bench for regfile_rename: directed vector table, reset/bypass sequences,
// and randomized traffic against an array-based reference model.
`default_nettype none

module tb_regfile_rename;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int TW   = 4;
  localparam int NRD  = 2;
  localparam int IW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rdy;
  logic [NRD*IW-1:0]    rd_idx;
  logic [NRD*XLEN-1:0]  rd_value;
  logic [NRD*TW-1:0]    rd_tag;
  logic [NRD-1:0]       rd_busy;
  logic                 ren_valid;
  logic [IW-1:0]        ren_reg;
  logic [TW-1:0]        ren_tag;
  logic                 cmt_valid;
  logic [IW-1:0]        cmt_reg;
  logic [TW-1:0]        cmt_tag;
  logic [XLEN-1:0]      cmt_value;
  logic                 flush;
  logic [IW:0]          busy_cnt;

  regfile_rename #(.XLEN(XLEN), .NREG(NREG), .ROB_TAG_W(TW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_idx(rd_idx), .rd_value(rd_value), .rd_tag(rd_tag), .rd_busy(rd_busy),
    .ren_valid(ren_valid), .ren_reg(ren_reg), .ren_tag(ren_tag),
    .cmt_valid(cmt_valid), .cmt_reg(cmt_reg), .cmt_tag(cmt_tag), .cmt_value(cmt_value),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] m_val [NREG];
  logic [3:0]  m_tag [NREG];
  bit          m_busy[NREG];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] rdy, renv, renr, rent, cmtv, cmtr, cmtt, cmtval, fl, rd0, rd1;
    logic [31:0] ev, et, eb, ecnt;
  } row_t;

  row_t rows[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 0;
    end
  endtask

  // Reference behaviour of one rising edge given the currently driven inputs.
  task automatic model_edge();
    bit ren_ok;
    if (rst) begin
      model_clear();
      return;
    end
    if (!rdy) return;
    ren_ok = ren_valid && !flush && (ren_reg != 0);
    if (cmt_valid && cmt_reg != 0) begin
      m_val[cmt_reg] = cmt_value;
      if (m_tag[cmt_reg] == cmt_tag && !(ren_ok && ren_reg == cmt_reg))
        m_busy[cmt_reg] = 0;
    end
    if (flush)
      for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    if (ren_ok) begin
      m_tag[ren_reg]  = ren_tag;
      m_busy[ren_reg] = 1;
    end
  endtask

  task automatic check_reads();
    int idx, cnt;
    logic [31:0] ev;
    logic [3:0]  et;
    bit          eb;
    for (int p = 0; p < NRD; p++) begin
      idx = int'(rd_idx[p*IW +: IW]);
      ev = m_val[idx]; et = m_tag[idx]; eb = m_busy[idx];
      if (idx == 0) begin
        ev = '0; et = '0; eb = 0;
      end
`ifdef REGFILE_BYPASS_EN
      if (idx != 0 && rdy && cmt_valid && int'(cmt_reg) == idx && m_busy[idx] &&
          m_tag[idx] == cmt_tag) begin
        ev = cmt_value; eb = 0;
      end
`endif
      chk($sformatf("rd_value[%0d] x%0d", p, idx), rd_value[p*XLEN +: XLEN], ev);
      chk($sformatf("rd_tag[%0d] x%0d", p, idx), 32'(rd_tag[p*TW +: TW]), 32'(et));
      chk($sformatf("rd_busy[%0d] x%0d", p, idx), 32'(rd_busy[p]), 32'(eb));
    end
    cnt = 0;
    for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    chk("busy_cnt", 32'(busy_cnt), 32'(cnt));
  endtask

  task automatic idle_inputs();
    ren_valid = 0; cmt_valid = 0; flush = 0; rdy = 1;
  endtask

  task automatic apply_row(input int n, input row_t r);
    rdy       = r.rdy[0];
    ren_valid = r.renv[0];
    ren_reg   = r.renr[IW-1:0];
    ren_tag   = r.rent[TW-1:0];
    cmt_valid = r.cmtv[0];
    cmt_reg   = r.cmtr[IW-1:0];
    cmt_tag   = r.cmtt[TW-1:0];
    cmt_value = r.cmtval;
    flush     = r.fl[0];
    rd_idx    = {r.rd1[IW-1:0], r.rd0[IW-1:0]};
    @(posedge clk);
    model_edge();
    #1 idle_inputs();
    #1;
    chk($sformatf("row%0d value", n), rd_value[XLEN-1:0], r.ev);
    chk($sformatf("row%0d tag", n), 32'(rd_tag[TW-1:0]), r.et);
    chk($sformatf("row%0d busy", n), 32'(rd_busy[0]), r.eb);
    chk($sformatf("row%0d busy_cnt", n), 32'(busy_cnt), r.ecnt);
    check_reads();
  endtask

  initial begin
    //          rdy renv renr rent cmtv cmtr cmtt cmtval        fl rd0 rd1  ev            et eb cnt
    rows[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,            0, 5, 0,  0,            0, 0, 0};
    rows[1]  = '{1, 1, 5, 3, 0, 0, 0, 0,            0, 5, 0,  0,            3, 1, 1};
    rows[2]  = '{1, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 5, 0,  32'hDEADBEEF, 3, 0, 0};
    rows[3]  = '{1, 1, 7, 2, 0, 0, 0, 0,            0, 7, 5,  0,            2, 1, 1};
    rows[4]  = '{1, 1, 7, 6, 0, 0, 0, 0,            0, 7, 5,  0,            6, 1, 1};
    rows[5]  = '{1, 0, 0, 0, 1, 7, 2, 32'h11,       0, 7, 5,  32'h11,       6, 1, 1};
    rows[6]  = '{1, 1, 9, 4, 1, 9, 1, 32'h22,       0, 9, 7,  32'h22,       4, 1, 2};
    rows[7]  = '{1, 1, 0, 5, 1, 0, 5, 32'h99,       0, 0, 9,  0,            0, 0, 2};
    rows[8]  = '{1, 1, 1, 1, 0, 0, 0, 0,            0, 1, 9,  0,            1, 1, 3};
    rows[9]  = '{1, 1, 2, 2, 0, 0, 0, 0,            0, 2, 1,  0,            2, 1, 4};
    rows[10] = '{1, 1, 3, 3, 0, 0, 0, 0,            0, 3, 2,  0,            3, 1, 5};
    rows[11] = '{0, 1, 6, 7, 1, 4, 0, 32'h33,       1, 4, 6,  0,            0, 0, 5};
    rows[12] = '{1, 1, 6, 7, 1, 4, 0, 32'h33,       1, 4, 6,  32'h33,       0, 0, 0};

    rst = 1; rdy = 1; ren_valid = 0; ren_reg = '0; ren_tag = '0;
    cmt_valid = 0; cmt_reg = '0; cmt_tag = '0; cmt_value = '0; flush = 0;
    rd_idx = {5'd9, 5'd5};
    model_clear();
    #2 check_reads();
    #10 rst = 0;
    @(posedge clk);
    model_edge();
    #2;

    for (int i = 0; i < 13; i++) apply_row(i, rows[i]);

    // Rename x10, then commit it while reading it in the same cycle.
    ren_valid = 1; ren_reg = 10; ren_tag = 5; rd_idx = {5'd9, 5'd10};
    @(posedge clk);
    model_edge();
    #1 ren_valid = 0;
    cmt_valid = 1; cmt_reg = 10; cmt_tag = 5; cmt_value = 32'h44;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass same-cycle value", rd_value[XLEN-1:0], 32'h44);
    chk("bypass same-cycle busy", 32'(rd_busy[0]), 32'd0);
`else
    chk("no-bypass same-cycle value", rd_value[XLEN-1:0], 32'd0);
    chk("no-bypass same-cycle busy", 32'(rd_busy[0]), 32'd1);
`endif
    check_reads();
    @(posedge clk);
    model_edge();
    #1 idle_inputs();
    #1;
    chk("post-commit x10 value", rd_value[XLEN-1:0], 32'h44);
    chk("post-commit x10 busy", 32'(rd_busy[0]), 32'd0);
    check_reads();

    // Asynchronous reset mid-cycle with pending rename/commit, held across an edge.
    rd_idx = {5'd12, 5'd9};
    ren_valid = 1; ren_reg = 12; ren_tag = 9;
    cmt_valid = 1; cmt_reg = 9; cmt_tag = 4; cmt_value = 32'h55;
    rst = 1;
    #1;
    model_clear();
    chk("async reset x9 value", rd_value[XLEN-1:0], 32'd0);
    chk("async reset busy_cnt", 32'(busy_cnt), 32'd0);
    @(posedge clk);
    model_edge();
    #1 check_reads();
    #2 rst = 0;
    cmt_valid = 0;
    @(posedge clk);
    model_edge();
    #1 idle_inputs();
    #1;
    chk("first rename after reset busy", 32'(rd_busy[1]), 32'd1);
    chk("first rename after reset tag", 32'(rd_tag[2*TW-1:TW]), 32'd9);
    check_reads();

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rdy       = ($urandom_range(0, 9) != 0);
      ren_valid = 1'($urandom_range(0, 1));
      ren_reg   = IW'($urandom_range(0, 7));
      ren_tag   = TW'($urandom_range(0, 3));
      cmt_valid = 1'($urandom_range(0, 1));
      cmt_reg   = IW'($urandom_range(0, 7));
      cmt_tag   = TW'($urandom_range(0, 3));
      cmt_value = $urandom;
      flush     = ($urandom_range(0, 19) == 0);
      rd_idx    = {IW'($urandom_range(0, 7)), IW'($urandom_range(0, 7))};
      #1 check_reads();
      @(posedge clk);
      model_edge();
    end
    #1 idle_inputs();
    #1 check_reads();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
